// File: rtl/sw_input_debounce_if.sv
// Switch-conditioning bundle: raw switch levels and IRQ ack in, debounced
// vector, edge masks and the sticky change flag out.
interface sw_input_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw_i;
  logic             irq_ack_i;
  logic [WIDTH-1:0] sw_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             change_o;
  logic             irq_o;

  // The debouncer itself.
  modport slave (
    input  sw_raw_i,
    input  irq_ack_i,
    output sw_o,
    output rise_o,
    output fall_o,
    output change_o,
    output irq_o
  );

  // Board/top-level side that supplies pins and consumes the conditioned vector.
  modport master (
    output sw_raw_i,
    output irq_ack_i,
    input  sw_o,
    input  rise_o,
    input  fall_o,
    input  change_o,
    input  irq_o
  );
endinterface

// File: rtl/sw_input_debounce.sv
// Switch bank conditioner: per-bit two-flop synchronizer, whole-vector
// debounce, rise/fall pulse masks on commit and a sticky change flag.
module sw_input_debounce #(
  parameter int               WIDTH         = 16,
  parameter int               STABLE_CYCLES = 2000,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  sw_input_debounce_if.slave bus
);

  localparam int             CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << 20)) begin : g_bad_stable_cycles
    $error("sw_input_debounce: STABLE_CYCLES must be in 1..2**20");
  end

  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] cand_reg;
  logic [WIDTH-1:0] sw_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             change_reg;
  logic             irq_reg;
  logic             commit;

  // Plain flop pair per bit; nothing may sit between the two stages.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_reg <= RESET_VAL[gi];
        s2_reg <= RESET_VAL[gi];
      end else begin
        s1_reg <= bus.sw_raw_i[gi];
        s2_reg <= s1_reg;
      end
    end

    assign sync_vec[gi] = s2_reg;
  end

  assign commit = (sync_vec == cand_reg) && (cand_reg != sw_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cand_reg   <= RESET_VAL;
      sw_reg     <= RESET_VAL;
      cnt_reg    <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      change_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      rise_reg   <= '0;
      fall_reg   <= '0;
      change_reg <= 1'b0;

      if (sync_vec != cand_reg) begin
        cand_reg <= sync_vec;
        cnt_reg  <= '0;
      end else if (cand_reg == sw_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        sw_reg     <= cand_reg;
        rise_reg   <= cand_reg & ~sw_reg;
        fall_reg   <= ~cand_reg & sw_reg;
        change_reg <= 1'b1;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      // Set follows the change pulse and beats an ack; an ack landing on the
      // commit edge is also ignored so a fresh event is never lost.
      irq_reg <= change_reg | (irq_reg & (~bus.irq_ack_i | commit));
    end
  end

  assign bus.sw_o     = sw_reg;
  assign bus.rise_o   = rise_reg;
  assign bus.fall_o   = fall_reg;
  assign bus.change_o = change_reg;
  assign bus.irq_o    = irq_reg;

endmodule

// File: doc/sw_input_debounce.md
Name: sw_input_debounce

Overview:
- Conditions the raw board switch bank before it reaches the core's switch input port.
- Each bit passes through a two-flop synchronizer; the vector is then debounced as a whole, so the core only sees a value after it has been stable for a set number of cycles.
- On each accepted change the block reports which bits rose and which fell, and sets a sticky event flag that a later GPIO/IRQ path can use to wake the core.
- Sits between the top-level switch pins and the core top's switch input.

Parameters:
WIDTH, 16, number of switch bits
STABLE_CYCLES, 2000, cycles the synchronized vector must hold before it is accepted (10 us at 200 MHz); legal range 1..2^20, elaboration error otherwise
RESET_VAL, 16'h0000, value of sw_o after reset (WIDTH bits)

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
sw_raw_i  input  WIDTH  raw asynchronous switch levels
irq_ack_i  input  1  clears irq_o (level, sampled each cycle)
sw_o  output  WIDTH  debounced switch vector to the core
rise_o  output  WIDTH  one-cycle pulse mask of bits that went 0->1 on commit
fall_o  output  WIDTH  one-cycle pulse mask of bits that went 1->0 on commit
change_o  output  1  one-cycle pulse on any commit
irq_o  output  1  sticky change flag

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i. All flops are on the rising edge of clk_i and reset asynchronously.
- Reset values:
  - sync stage 1 and sync stage 2 = RESET_VAL; candidate = RESET_VAL; sw_o = RESET_VAL.
  - counter = 0; rise_o, fall_o = 0; change_o = 0; irq_o = 0.
- Synchronizer: s1 <= sw_raw_i; sync <= s1. No logic between the two flops.
- Candidate/counter, evaluated each cycle in this priority:
  1. sync != candidate: candidate <= sync; counter <= 0; no commit.
  2. else candidate == sw_o: counter <= 0; idle, no event.
  3. else counter == STABLE_CYCLES-1: commit. sw_o <= candidate; rise_o <= candidate & ~sw_o; fall_o <= ~candidate & sw_o; change_o <= 1; counter <= 0.
  4. else counter <= counter + 1.
- Counter width: $clog2(STABLE_CYCLES) bits, minimum 1. It never wraps, because it is cleared at STABLE_CYCLES-1.
- Pulse outputs: rise_o, fall_o and change_o are 0 in every cycle without a commit. Invariant: rise_o & fall_o == 0.
- Latency: a raw step that is stable from the edge it is first sampled (edge E1) produces the commit at edge E(STABLE_CYCLES+3). With STABLE_CYCLES=4 the commit is at E7.
- Glitch rejection:
  - A pulse or bounce shorter than STABLE_CYCLES cycles after synchronization reloads the candidate and restarts the count.
  - If the signal settles back to the current sw_o, no commit and no event occur.
- Multi-bit change: bits changing on different cycles restart the count each time. The commit is a single atomic vector update, never a partial one.
- irq_o:
  - Set on the cycle after a commit.
  - Cleared on the cycle after irq_ack_i=1.
  - If a commit and irq_ack_i=1 occur in the same cycle, set wins and irq_o stays 1.
- Reset mid-count: the asynchronous assert immediately forces every reset value, and any pending change is discarded. After deassert, the raw value is re-synchronized and fully re-debounced from counter 0.

Test Plan (STABLE_CYCLES=4, 200 MHz clk, RESET_VAL=0):
- Reset held 10 ns with sw_raw_i=16'hAE4A, then released -> all outputs 0 during reset. After release, sw_o=16'hAE4A at release edge+7; rise_o=16'hAE4A, fall_o=0, change_o=1 for exactly 1 cycle; irq_o=1 from the next cycle.
- From sw_o=16'hAE4A, raw changes to 16'hA800 -> 7 edges later: sw_o=16'hA800, fall_o=16'h064A, rise_o=0, single change_o pulse. Then raw 16'hFFFF -> sw_o=16'hFFFF, rise_o=16'h57FF, fall_o=0.
- Glitch: sw_o=16'hA800, raw bit 0 driven high for 2 cycles then low -> sw_o unchanged, no change_o, irq_o unchanged. Bounce of 3 toggles 1 cycle apart, then holding 1 -> exactly one commit, 7 edges after the last toggle.
- irq handling:
  - irq_o=1, irq_ack_i=1 for 1 cycle with no commit -> irq_o=0 on the next cycle.
  - Ack asserted in the same cycle as a commit -> irq_o remains 1.
- Reset mid-count: raw 0 -> 16'h00FF, rst_n_i asserted 3 cycles after the step -> sw_o=0 immediately, counter cleared. After deassert with raw still 16'h00FF, the commit happens at deassert edge+7, not earlier.
- Staggered multi-bit change: bit 15 rises, then bit 14 rises 2 cycles later -> one commit with rise_o=16'hC000, 7 edges after the bit 14 step; no intermediate sw_o=16'h8000.
